// File: rtl/snake_decoder.sv
// snake_decoder: decodes a 16-LED frame into three snake heads/directions over a 16-cycle bit scan.
// Define SNAKE_DEC_STEP_CHECK_EN to reject frames that move any head by more than one position.
module snake_decoder #(
  parameter int MOVE_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  sample,
  input  logic [15:0]           led_in,
  output logic                  busy,
  output logic                  valid,
  output logic                  err,
  output logic [3:0]            s1_pos,
  output logic [3:0]            s2_pos,
  output logic [3:0]            s3_pos,
  output logic                  s1_dir,
  output logic                  s2_dir,
  output logic                  s3_dir,
  output logic [MOVE_CNT_W-1:0] move_cnt
);
  typedef enum logic [1:0] {IDLE, SCAN, CHECK} state_t;
  state_t      r_state, w_next;
  logic [15:0] r_frame;
  logic [3:0]  r_idx, r_start;
  logic [4:0]  r_len;
  logic [2:0]  r_runs, r_ok;
  logic [3:0]  r_head [3];
  logic        r_pend, r_legal, r_moved;
  logic        w_bit, w_close, w_shape, w_moved, w_legal;
  logic [4:0]  w_clen;
  logic [3:0]  w_chead;
  assign busy    = r_state != IDLE;
  assign w_bit   = r_frame[r_idx];
  // r_len is zero outside a run, so it doubles as the "previous bit was 1" flag
  assign w_close = (r_len != 5'd0 && !w_bit) || (w_bit && r_idx == 4'd0);
  assign w_clen  = w_bit ? r_len + 5'd1 : r_len;
  assign w_chead = r_len != 5'd0 ? r_start : r_idx;
  assign w_shape = r_runs == 3'd3 && &r_ok;
  assign w_moved = r_head[0] != s1_pos || r_head[1] != s2_pos || r_head[2] != s3_pos;
`ifdef SNAKE_DEC_STEP_CHECK_EN
  function automatic logic far(input logic [3:0] a, input logic [3:0] b);
    return (a > b ? a - b : b - a) > 4'd1;
  endfunction
  assign w_legal = w_shape && !far(r_head[0], s1_pos) && !far(r_head[1], s2_pos) && !far(r_head[2], s3_pos);
`else
  assign w_legal = w_shape;
`endif
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && sample && en) w_next = SCAN;
    if (r_state == SCAN && r_idx == 4'd0) w_next = CHECK;
    if (r_state == CHECK) w_next = IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_frame <= '0;
      r_idx   <= '0;
      r_start <= '0;
      r_len   <= '0;
      r_runs  <= '0;
      r_ok    <= '0;
      r_head  <= '{default: '0};
      r_pend  <= 1'b0;
      r_legal <= 1'b0;
      r_moved <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pend  <= r_state == CHECK;
      if (r_state == IDLE && sample && en) begin
        r_frame <= led_in;
        r_idx   <= 4'd15;
        r_len   <= '0;
        r_runs  <= '0;
        r_ok    <= '0;
      end
      if (r_state == SCAN) begin
        r_idx <= r_idx - 4'd1;
        r_len <= w_bit ? w_clen : 5'd0;
        if (w_bit && r_len == 5'd0) r_start <= r_idx;
        if (w_close) begin
          for (int k = 0; k < 3; k++)
            if (r_runs == 3'(k)) begin
              r_head[k] <= w_chead;
              r_ok[k]   <= w_clen == 5'(k + 1);
            end
          r_runs <= r_runs == 3'd7 ? r_runs : r_runs + 3'd1;
        end
      end
      if (r_state == CHECK) begin
        r_legal <= w_legal;
        r_moved <= w_moved;
      end
    end
  end
  // results land one edge after CHECK so the valid pulse sits on the 18th edge after acceptance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid    <= 1'b0;
      err      <= 1'b0;
      s1_pos   <= 4'd15;
      s2_pos   <= 4'd11;
      s3_pos   <= 4'd2;
      s1_dir   <= 1'b0;
      s2_dir   <= 1'b0;
      s3_dir   <= 1'b1;
      move_cnt <= '0;
    end else begin
      valid <= r_pend;
      if (r_pend) begin
        err <= !r_legal;
        if (r_legal) begin
          s1_pos <= r_head[0];
          s2_pos <= r_head[1];
          s3_pos <= r_head[2];
          s1_dir <= r_head[0] > s1_pos ? 1'b1 : r_head[0] < s1_pos ? 1'b0 : s1_dir;
          s2_dir <= r_head[1] > s2_pos ? 1'b1 : r_head[1] < s2_pos ? 1'b0 : s2_dir;
          s3_dir <= r_head[2] > s3_pos ? 1'b1 : r_head[2] < s3_pos ? 1'b0 : s3_dir;
          if (r_moved && !(&move_cnt)) move_cnt <= move_cnt + MOVE_CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_snake_decoder.sv
// tb_snake_decoder: frame-level model of snake_decoder checked every cycle, plus directed literal checks.
module tb_snake_decoder;
  logic        clk = 1'b0, rst = 1'b1, en = 1'b0, sample = 1'b0;
  logic [15:0] led_in = '0;
  logic        busy, valid, err, s1_dir, s2_dir, s3_dir;
  logic [3:0]  s1_pos, s2_pos, s3_pos;
  logic [7:0]  move_cnt;
  int n_checks = 0, n_errors = 0, n_valid = 0, v0;
  int m_pos [3], m_dir [3], m_cnt, m_err, m_valid, scan_e;
  logic        pend;
  logic [15:0] m_frame;

  snake_decoder #(.MOVE_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .sample(sample), .led_in(led_in),
    .busy(busy), .valid(valid), .err(err),
    .s1_pos(s1_pos), .s2_pos(s2_pos), .s3_pos(s3_pos),
    .s1_dir(s1_dir), .s2_dir(s2_dir), .s3_dir(s3_dir),
    .move_cnt(move_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = '{15, 11, 2};
    m_dir = '{0, 0, 1};
    m_cnt = 0; m_err = 0; m_valid = 0; scan_e = -1; pend = 1'b0;
  endtask

  // Decode a whole frame into runs, then apply the snake update rules.
  task automatic apply(input logic [15:0] f);
    int heads[$], lens[$];
    bit legal, moved;
    for (int i = 15; i >= 0; i--)
      if (f[i] && (i == 15 || !f[i+1])) begin
        heads.push_back(i);
        lens.push_back(1);
      end else if (f[i]) lens[lens.size()-1]++;
    legal = heads.size() == 3 && lens[0] == 1 && lens[1] == 2 && lens[2] == 3;
`ifdef SNAKE_DEC_STEP_CHECK_EN
    if (legal)
      for (int k = 0; k < 3; k++)
        if (heads[k] - m_pos[k] > 1 || m_pos[k] - heads[k] > 1) legal = 0;
`endif
    m_err = legal ? 0 : 1;
    if (legal) begin
      moved = 0;
      for (int k = 0; k < 3; k++) begin
        if (heads[k] != m_pos[k]) moved = 1;
        if (heads[k] > m_pos[k]) m_dir[k] = 1;
        if (heads[k] < m_pos[k]) m_dir[k] = 0;
        m_pos[k] = heads[k];
      end
      if (moved && m_cnt < 255) m_cnt++;
    end
  endtask

  always @(posedge clk) begin
    if (!rst) model_reset();
    else begin
      m_valid = 0;
      if (pend) begin
        apply(m_frame);
        m_valid = 1;
        pend = 1'b0;
      end
      if (scan_e >= 0) begin
        scan_e++;
        if (scan_e == 17) begin
          scan_e = -1;
          pend = 1'b1;
        end
      end else if (sample && en) begin
        scan_e = 0;
        m_frame = led_in;
      end
    end
    #1;
    check("busy", 32'(busy), 32'(scan_e >= 0));
    check("valid", 32'(valid), 32'(m_valid));
    check("err", 32'(err), 32'(m_err));
    check("s1_pos", 32'(s1_pos), 32'(m_pos[0]));
    check("s2_pos", 32'(s2_pos), 32'(m_pos[1]));
    check("s3_pos", 32'(s3_pos), 32'(m_pos[2]));
    check("s1_dir", 32'(s1_dir), 32'(m_dir[0]));
    check("s2_dir", 32'(s2_dir), 32'(m_dir[1]));
    check("s3_dir", 32'(s3_dir), 32'(m_dir[2]));
    check("move_cnt", 32'(move_cnt), 32'(m_cnt));
    if (valid) n_valid++;
  end

  task automatic send(input logic [15:0] v);
    @(negedge clk);
    en = 1'b1; sample = 1'b1; led_in = v;
    @(negedge clk);
    sample = 1'b0; led_in = ~v;
    repeat (20) @(negedge clk);
  endtask

  task automatic expect_state(input string tag, input int p1, input int p2, input int p3,
                              input int d1, input int d2, input int d3, input int c, input int e);
    check({tag, "_s1"}, 32'(s1_pos), 32'(p1));
    check({tag, "_s2"}, 32'(s2_pos), 32'(p2));
    check({tag, "_s3"}, 32'(s3_pos), 32'(p3));
    check({tag, "_d1"}, 32'(s1_dir), 32'(d1));
    check({tag, "_d2"}, 32'(s2_dir), 32'(d2));
    check({tag, "_d3"}, 32'(s3_dir), 32'(d3));
    check({tag, "_cnt"}, 32'(move_cnt), 32'(c));
    check({tag, "_err"}, 32'(err), 32'(e));
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    expect_state("reset", 15, 11, 2, 0, 0, 1, 0, 0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    send(16'h8C07);
    expect_state("f8C07", 15, 11, 2, 0, 0, 1, 0, 0);
    check("f8C07_valids", 32'(n_valid), 32'd1);
    send(16'h4C07);
    expect_state("f4C07", 14, 11, 2, 0, 0, 1, 1, 0);
    send(16'h8E07);
    expect_state("f8E07", 14, 11, 2, 0, 0, 1, 1, 1);
    send(16'h4C70);
`ifdef SNAKE_DEC_STEP_CHECK_EN
    expect_state("f4C70", 14, 11, 2, 0, 0, 1, 1, 1);
`else
    expect_state("f4C70", 14, 11, 6, 0, 0, 1, 2, 0);
`endif
    v0 = n_valid;
    @(negedge clk); sample = 1'b1; led_in = 16'h8C07;
    @(negedge clk); sample = 1'b0;
    repeat (5) @(negedge clk);
    sample = 1'b1; led_in = 16'h4C07;
    @(negedge clk); sample = 1'b0;
    repeat (20) @(negedge clk);
    check("busy_sample_valids", 32'(n_valid - v0), 32'd1);
    check("busy_sample_s1", 32'(s1_pos), 32'd15);
    @(negedge clk); sample = 1'b1; led_in = 16'h4C07;
    @(negedge clk); sample = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    expect_state("midrst", 15, 11, 2, 0, 0, 1, 0, 0);
    v0 = n_valid;
    @(negedge clk); @(negedge clk); rst = 1'b1;
    repeat (25) @(negedge clk);
    check("midrst_no_valid", 32'(n_valid - v0), 32'd0);
    en = 1'b0;
    v0 = n_valid;
    @(negedge clk); sample = 1'b1; led_in = 16'h4C07;
    @(negedge clk); sample = 1'b0;
    check("en0_busy", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
    check("en0_no_valid", 32'(n_valid - v0), 32'd0);
    check("en0_s1", 32'(s1_pos), 32'd15);
    for (int i = 0; i < 300; i++) send(i % 2 ? 16'h8C07 : 16'h4C07);
    check("sat_cnt", 32'(move_cnt), 32'd255);
    check("sat_s1", 32'(s1_pos), 32'd15);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/snake_decoder.md
SNAKE_DECODER -- requirements
Module: snake_decoder

Interface
REQ-001 SHALL have parameter MOVE_CNT_W, default 8, giving the width of move_cnt.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port en  input  1  high permits acceptance of sample.
REQ-005 SHALL have port sample  input  1  one-cycle strobe to capture led_in.
REQ-006 SHALL have port led_in  input  16  LED pattern; bit 15 leftmost.
REQ-007 SHALL have port busy  output  1  high while a frame is being decoded.
REQ-008 SHALL have port valid  output  1  one-cycle pulse when a frame decode completes.
REQ-009 SHALL have port err  output  1  frame illegal; updated with valid and held until the next valid.
REQ-010 SHALL have ports s1_pos, s2_pos, s3_pos  output  4 each  head (highest bit) of each snake.
REQ-011 SHALL have ports s1_dir, s2_dir, s3_dir  output  1 each  1 = LEFT (up), 0 = RIGHT (down).
REQ-012 SHALL have port move_cnt  output  MOVE_CNT_W  count of legal frames in which any snake moved.

Function
REQ-013 SHALL use FSM states IDLE, SCAN, CHECK; transitions IDLE->SCAN on sample & en, SCAN->CHECK after 16 cycles, CHECK->IDLE.
REQ-014 SHALL register led_in on the accepting edge; later changes of led_in SHALL NOT affect the frame.
REQ-015 SHALL examine one bit per SCAN cycle, index 15 down to 0, tracking run start, run length and run count.
REQ-016 SHALL treat a run as closed at a 1->0 transition or when bit 0 is 1.
REQ-017 SHALL accept a frame as legal only if it has exactly three runs, left to right, of lengths 1, 2 and 3.
REQ-018 SHALL take snake k head = highest bit index of run k.
REQ-019 SHALL assert busy from the edge after acceptance until return to IDLE.
REQ-020 SHALL update outputs and pulse valid for exactly one cycle on the 18th rising edge after the accepting edge.
REQ-021 On a legal frame: per snake, new head > old head sets dir=1, new < old sets dir=0, equal holds dir; positions take the new heads.
REQ-022 On a legal frame with at least one head changed, move_cnt SHALL increment, saturating at all-ones.
REQ-023 On an illegal frame: err=1; positions, dirs and move_cnt SHALL hold.
REQ-024 SHALL ignore sample while busy, and while en is low in IDLE.
REQ-025 Once accepted, a scan SHALL complete regardless of en.

Reset
REQ-026 rst low SHALL immediately force IDLE, busy=0, valid=0, err=0, move_cnt=0.
REQ-027 rst low SHALL set s1_pos=15, s2_pos=11, s3_pos=2, s1_dir=0, s2_dir=0, s3_dir=1.
REQ-028 Reset mid-scan SHALL abort the frame with no valid pulse.

Configuration
REQ-029 Macro SNAKE_DEC_STEP_CHECK_EN defined: a frame that is otherwise legal but moves any head by more than 1 from its current position SHALL be illegal (REQ-023).
REQ-030 Macro SNAKE_DEC_STEP_CHECK_EN undefined: any displacement SHALL be accepted, and no step-check logic SHALL be present.

Verification
REQ-031 Reset, then sample with led_in=16'h8C07 -> valid at +18 edges; s1/s2/s3=15/11/2, err=0, dirs 0/0/1, move_cnt=0.
REQ-032 Next, sample with 16'h4C07 -> s1_pos=14, s1_dir=0, others unchanged, move_cnt=1, err=0.
REQ-033 Next, sample with 16'h8E07 (run lengths 1,3,3) -> err=1; positions 14/11/2 held; move_cnt=1.
REQ-034 Next, sample with 16'h4C70 -> with macro: err=1, s3_pos=2 held; without macro: s3_pos=6, s3_dir=1, move_cnt=2.
REQ-035 Second sample pulse during busy -> ignored, exactly one valid; rst low at scan cycle 8 -> busy=0, REQ-027 values, no valid.
REQ-036 en=0 with sample pulse -> busy stays 0, no valid; 300 legal moving frames with MOVE_CNT_W=8 -> move_cnt=255.
